// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences fetch/load/store accesses to a byte-addressed
// memory. Each accepted operation is IDLE -> ACCESS -> RESP (3 cycles).
// A rejected operation skips ACCESS and goes straight to RESP.
//
// Optional feature: define STORE_PROTECT_EN to reject stores below
// PROT_LIMIT (the protected program region).
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (accept on edge when both high)
//   req_op                 00 fetch, 01 load, 10 store, 11 reserved
//   req_addr, req_wdata    load/store address, store data
//   pc_load, pc_in         branch: load PC (IDLE only, wins over a request)
//   pc, instr, rdata       program counter, last instruction, last load data
//   done, err              one-cycle completion pulse, rejected qualifier
//   mem_add/mem_write/mem_wd/mem_rd   memory port (mem_rd is combinational)
module mem_access_ctrl #(
  parameter logic [7:0] PC_RESET   = 8'd0,
  parameter logic [7:0] PROT_LIMIT = 8'd44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        pc_load,
  input  logic [7:0]  pc_in,
  output logic [7:0]  pc,
  output logic [19:0] instr,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        err,
  output logic [7:0]  mem_add,
  output logic        mem_write,
  output logic [7:0]  mem_wd,
  input  logic [19:0] mem_rd
);

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic [7:0] addr_q, wdata_q;
  logic       rej_q;

  logic       accept, reject, prot_hit;
  logic [7:0] acc_addr;

  assign req_ready = (state == IDLE) && !pc_load;
  assign accept    = req_valid && req_ready;
  // Fetches take their address from the PC, not from req_addr.
  assign acc_addr  = (req_op == OP_FETCH) ? pc : req_addr;

`ifdef STORE_PROTECT_EN
  assign prot_hit = (req_op == OP_STORE) && (req_addr < PROT_LIMIT);
`else
  logic prot_unused;
  assign prot_unused = ^PROT_LIMIT;
  assign prot_hit    = 1'b0;
`endif

  // A 4-byte window starting above 252 would run off the end of memory.
  assign reject = (acc_addr > 8'd252) || (req_op == OP_RSVD) || prot_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= PC_RESET;
      instr   <= '0;
      rdata   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rej_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pc_load) pc <= pc_in;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= acc_addr;
        wdata_q <= req_wdata;
        rej_q   <= reject;
      end
      // ACCESS is only ever entered for non-rejected operations.
      if (state == ACCESS) begin
        case (op_q)
          OP_FETCH: begin
            instr <= mem_rd;
            pc    <= pc + 8'd4;
          end
          OP_LOAD: rdata <= mem_rd[7:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_add   = '0;
    mem_write = 1'b0;
    mem_wd    = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = reject ? RESP : ACCESS;
      ACCESS: begin
        mem_add   = addr_q;
        mem_write = (op_q == OP_STORE);
        mem_wd    = (op_q == OP_STORE) ? wdata_q : 8'd0;
        state_nxt = RESP;
      end
      RESP: begin
        done      = 1'b1;
        err       = rej_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam logic [7:0] PC_RST = 8'd0;
  localparam logic [7:0] PLIM   = 8'd44;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_addr = 8'd0, req_wdata = 8'd0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_in = 8'd0;
  logic [7:0]  pc, rdata, mem_add, mem_wd;
  logic [19:0] instr;
  logic        done, err, mem_write;
  logic [19:0] mem_rd = 20'd0;

  mem_access_ctrl #(.PC_RESET(PC_RST), .PROT_LIMIT(PLIM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .pc_load(pc_load), .pc_in(pc_in), .pc(pc), .instr(instr), .rdata(rdata),
    .done(done), .err(err), .mem_add(mem_add), .mem_write(mem_write),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: 'age' is cycles since the accept edge.
  // A good op spends its first cycle on the memory and its second in
  // response; a rejected op responds in its first cycle.
  int          age = 0;
  bit          m_rej = 1'b0;
  logic [1:0]  m_op = 2'b00;
  logic [7:0]  m_addr = 8'd0, m_wd = 8'd0, m_pc = 8'd0, m_rdata = 8'd0;
  logic [19:0] m_instr = 20'd0;

  function automatic int span();
    return m_rej ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      age = 0; m_pc = PC_RST; m_instr = 20'd0; m_rdata = 8'd0;
    end else if (age == 0) begin
      if (pc_load) m_pc = pc_in;
      else if (req_valid) begin
        m_op   = req_op;
        m_addr = (req_op == 2'b00) ? m_pc : req_addr;
        m_wd   = req_wdata;
        m_rej  = (m_addr > 8'd252) || (req_op == 2'b11);
`ifdef STORE_PROTECT_EN
        if (req_op == 2'b10 && req_addr < PLIM) m_rej = 1'b1;
`endif
        age = 1;
      end
    end else if (age == span()) begin
      age = 0;
    end else begin
      if (m_op == 2'b00) begin m_instr = mem_rd; m_pc = m_pc + 8'd4; end
      else if (m_op == 2'b01) m_rdata = mem_rd[7:0];
      age = 2;
    end
  end

  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] last_wa = 8'd0, last_wd = 8'd0;

  // Per-cycle compare against the model, plus event counters.
  always @(negedge clk) begin
    if (chk_en) begin
      bit act_e, done_e;
      act_e  = (age == 1) && !m_rej;
      done_e = (age != 0) && (age == span());
      chk("req_ready", 32'(req_ready), 32'((age == 0) && !pc_load));
      chk("done",      32'(done),      32'(done_e));
      chk("err",       32'(err),       32'(done_e && m_rej));
      chk("mem_add",   32'(mem_add),   32'(act_e ? m_addr : 8'd0));
      chk("mem_write", 32'(mem_write), 32'(act_e && m_op == 2'b10));
      chk("mem_wd",    32'(mem_wd),    32'((act_e && m_op == 2'b10) ? m_wd : 8'd0));
      chk("pc",        32'(pc),        32'(m_pc));
      chk("instr",     32'(instr),     32'(m_instr));
      chk("rdata",     32'(rdata),     32'(m_rdata));
      if (mem_write) begin wr_cnt++; last_wa = mem_add; last_wd = mem_wd; end
      if (done) done_cnt++;
      if (done && err) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One operation, with busy-time noise on the request and pc_load lines
  // that the block must ignore.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] wd, input logic [19:0] rd);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; mem_rd = rd;
    tick();
    req_op = 2'b10; req_addr = 8'hC3; req_wdata = 8'hEE;
    pc_load = 1'b1; pc_in = 8'h99;
    tick();
    req_valid = 1'b0; req_op = 2'b00; req_addr = 8'd0; req_wdata = 8'd0;
    pc_load = 1'b0;
    tick(); tick();
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_load = 1'b1; pc_in = v;
    tick();
    pc_load = 1'b0;
  endtask

  int d0, e0, w0;

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_pc", 32'(pc), 32'(PC_RST));
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Fetch at pc 0.
    d0 = done_cnt; e0 = err_cnt;
    do_op(2'b00, 8'h77, 8'd0, 20'hE0408);
    chk("fetch_instr", 32'(instr), 32'hE0408);
    chk("fetch_pc", 32'(pc), 32'd4);
    chk("fetch_done", 32'(done_cnt - d0), 32'd1);
    chk("fetch_noerr", 32'(err_cnt - e0), 32'd0);

    // Store then load back.
    w0 = wr_cnt;
    do_op(2'b10, 8'd100, 8'h5A, 20'd0);
    chk("st_wcnt", 32'(wr_cnt - w0), 32'd1);
    chk("st_addr", 32'(last_wa), 32'd100);
    chk("st_data", 32'(last_wd), 32'h5A);
    do_op(2'b01, 8'd100, 8'd0, 20'hFFF33);
    chk("ld_low_byte", 32'(rdata), 32'h33);
    do_op(2'b01, 8'd100, 8'd0, 20'h0005A);
    chk("ld_rdata", 32'(rdata), 32'h5A);

    // Branch to 252, fetch wraps pc to 0.
    set_pc(8'd252);
    chk("pcload_pc", 32'(pc), 32'd252);
    do_op(2'b00, 8'd0, 8'd0, 20'h12345);
    chk("wrap_instr", 32'(instr), 32'h12345);
    chk("wrap_pc", 32'(pc), 32'd0);

    // Load beyond 252 rejected.
    e0 = err_cnt; w0 = wr_cnt;
    do_op(2'b01, 8'd253, 8'd0, 20'hAAAAA);
    chk("ld253_err", 32'(err_cnt - e0), 32'd1);
    chk("ld253_nowr", 32'(wr_cnt - w0), 32'd0);
    chk("ld253_rdata", 32'(rdata), 32'h5A);

    // pc_load wins over a simultaneous request.
    d0 = done_cnt;
    pc_load = 1'b1; pc_in = 8'd40; req_valid = 1'b1; req_op = 2'b01; req_addr = 8'd7;
    tick();
    pc_load = 1'b0; req_valid = 1'b0;
    tick(); tick();
    chk("pcwin_pc", 32'(pc), 32'd40);
    chk("pcwin_nodone", 32'(done_cnt - d0), 32'd0);

    // Reserved op.
    e0 = err_cnt;
    do_op(2'b11, 8'd8, 8'd0, 20'd0);
    chk("rsvd_err", 32'(err_cnt - e0), 32'd1);

    // Store into the program region.
    e0 = err_cnt; w0 = wr_cnt;
    do_op(2'b10, 8'd10, 8'hA1, 20'd0);
`ifdef STORE_PROTECT_EN
    chk("prot10_err", 32'(err_cnt - e0), 32'd1);
    chk("prot10_nowr", 32'(wr_cnt - w0), 32'd0);
`else
    chk("st10_wr", 32'(wr_cnt - w0), 32'd1);
    chk("st10_addr", 32'(last_wa), 32'd10);
`endif
    e0 = err_cnt; w0 = wr_cnt;
    do_op(2'b10, 8'd44, 8'h3C, 20'd0);
    chk("st44_wr", 32'(wr_cnt - w0), 32'd1);
    chk("st44_addr", 32'(last_wa), 32'd44);
    chk("st44_noerr", 32'(err_cnt - e0), 32'd0);

    // Address boundary 252/253 for stores.
    w0 = wr_cnt;
    do_op(2'b10, 8'd252, 8'h77, 20'd0);
    chk("st252_wr", 32'(wr_cnt - w0), 32'd1);
    e0 = err_cnt; w0 = wr_cnt;
    do_op(2'b10, 8'd253, 8'h77, 20'd0);
    chk("st253_err", 32'(err_cnt - e0), 32'd1);
    chk("st253_nowr", 32'(wr_cnt - w0), 32'd0);

    // Fetch from pc 253 rejected, pc untouched.
    set_pc(8'd253);
    e0 = err_cnt;
    do_op(2'b00, 8'd0, 8'd0, 20'hBBBBB);
    chk("f253_err", 32'(err_cnt - e0), 32'd1);
    chk("f253_pc", 32'(pc), 32'd253);

    // Reset during ACCESS of a fetch.
    set_pc(8'd16);
    do_op(2'b00, 8'd0, 8'd0, 20'h55555);
    chk("f16_pc", 32'(pc), 32'd20);
    d0 = done_cnt;
    req_valid = 1'b1; req_op = 2'b00; mem_rd = 20'h66666;
    tick();
    req_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstf_ready", 32'(req_ready), 32'd1);
    chk("rstf_pc", 32'(pc), 32'(PC_RST));
    chk("rstf_instr", 32'(instr), 32'd0);
    tick(); tick();
    chk("rstf_nodone", 32'(done_cnt - d0), 32'd0);

    // Reset during ACCESS of a store: the same-cycle write only.
    d0 = done_cnt; w0 = wr_cnt;
    req_valid = 1'b1; req_op = 2'b10; req_addr = 8'd120; req_wdata = 8'h11;
    tick();
    req_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rsts_wr", 32'(wr_cnt - w0), 32'd1);
    chk("rsts_nodone", 32'(done_cnt - d0), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
